// File: rtl/auth_display_ctrl.sv
// auth_display_ctrl: keypad authentication sequencer feeding the dual
// 7-segment driver. It collects DIGITS keypad digits, compares them with KEY,
// counts failed attempts and enforces a timed lockout. Display 2 shows a
// status character and display 1 shows a number.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | waiting for the first digit, shows tries remaining
// S_ENTRY     | collecting digits, shows digit count
// S_CHECK     | one-cycle compare of the entered code against KEY
// S_FAIL      | wrong code, error message shown for MSG_CYCLES
// S_LOCKED    | too many failures, all input ignored for LOCK_CYCLES
// S_UNLOCKED  | access granted until lock_req
module auth_display_ctrl #(
   parameter int                  DIGITS      = 4,
   parameter logic [4*DIGITS-1:0] KEY         = 16'h1234,
   parameter int                  MAX_TRIES   = 3,
   parameter int                  MSG_CYCLES  = 50_000_000,
   parameter int                  LOCK_CYCLES = 500_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   output logic       key_ready,
   input  logic       clear,
   input  logic       lock_req,
   output logic [3:0] bcd1,
   output logic [3:0] bcd2,
   output logic       shift,
   output logic       unlocked,
   output logic       locked
);

   localparam int TW  = $clog2(LOCK_CYCLES + 1);
   localparam int DCW = $clog2(DIGITS + 1);
   localparam logic [TW-1:0]  MSG_LOAD  = TW'(MSG_CYCLES - 1);
   localparam logic [TW-1:0]  LOCK_LOAD = TW'(LOCK_CYCLES - 1);
   localparam logic [DCW-1:0] LAST_DIG  = DCW'(DIGITS - 1);

   // Display-2 character codes understood by the driver in shift mode.
   localparam logic [3:0] CH_DASH   = 4'h8;
   localparam logic [3:0] CH_ERR    = 4'h5;
   localparam logic [3:0] CH_LOCK   = 4'h6;
   localparam logic [3:0] CH_UNLOCK = 4'h7;
   localparam logic [3:0] BLANK     = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTRY,
      S_CHECK,
      S_FAIL,
      S_LOCKED,
      S_UNLOCKED
   } state_t;

   state_t                r_state;
   logic [DCW-1:0]        r_dig_cnt;
   logic [4*DIGITS-1:0]   r_code;
   logic [3:0]            r_fail_cnt;
   logic [TW-1:0]         r_timer;
   logic                  w_accept;

   assign w_accept = key_valid && key_ready;

   // Sequencer: digit collection, compare, failure counting and timers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_dig_cnt  <= '0;
         r_code     <= '0;
         r_fail_cnt <= '0;
         r_timer    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_code    <= {r_code[4*DIGITS-5:0], key_digit};
                  r_dig_cnt <= DCW'(1);
                  r_state   <= S_ENTRY;
               end
            end
            S_ENTRY: begin
               // clear beats a simultaneous digit so a half-typed code never survives
               if (clear) begin
                  r_dig_cnt <= '0;
                  r_state   <= S_IDLE;
               end else if (w_accept) begin
                  r_code    <= {r_code[4*DIGITS-5:0], key_digit};
                  r_dig_cnt <= r_dig_cnt + DCW'(1);
                  if (r_dig_cnt == LAST_DIG) begin
                     r_state <= S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               r_dig_cnt <= '0;
               if (r_code == KEY) begin
                  r_fail_cnt <= '0;
                  r_state    <= S_UNLOCKED;
               end else if (int'(r_fail_cnt) + 1 < MAX_TRIES) begin
                  r_fail_cnt <= r_fail_cnt + 4'd1;
                  r_timer    <= MSG_LOAD;
                  r_state    <= S_FAIL;
               end else begin
                  r_timer <= LOCK_LOAD;
                  r_state <= S_LOCKED;
               end
            end
            S_FAIL: begin
               if (r_timer == '0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
            S_LOCKED: begin
               if (r_timer == '0) begin
                  r_fail_cnt <= '0;
                  r_state    <= S_IDLE;
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
            S_UNLOCKED: begin
               if (lock_req) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Output decode from registered state only; no input reaches an output.
   always_comb begin
      key_ready = 1'b0;
      bcd1      = BLANK;
      bcd2      = CH_DASH;
      shift     = 1'b1;
      unlocked  = 1'b0;
      locked    = 1'b0;
      case (r_state)
         S_IDLE: begin
            key_ready = 1'b1;
            bcd1      = 4'(MAX_TRIES) - r_fail_cnt;
         end
         S_ENTRY: begin
            key_ready = 1'b1;
            bcd1      = 4'(r_dig_cnt);
         end
         S_CHECK: begin
            bcd1 = 4'(DIGITS);
         end
         S_FAIL: begin
            bcd1 = 4'(MAX_TRIES) - r_fail_cnt;
            bcd2 = CH_ERR;
         end
         S_LOCKED: begin
            bcd2   = CH_LOCK;
            locked = 1'b1;
         end
         S_UNLOCKED: begin
            bcd2     = CH_UNLOCK;
            unlocked = 1'b1;
         end
         default: begin
            bcd1 = BLANK;
         end
      endcase
   end

endmodule
